// File: rtl/rs_encoder_stream.sv
// Byte-serial systematic Reed-Solomon encoder over GF(256) (poly 0x11D): K message bytes pass through, then 16 parity bytes.
// Build option RS_ENC_ERR_INJECT_EN adds port err_inj, an XOR mask applied to the first parity byte of each codeword.
module rs_encoder_stream #(
  parameter int K    = 239,
  parameter int NPAR = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_sop,
  output logic       out_last
`ifdef RS_ENC_ERR_INJECT_EN
  ,
  input  logic [7:0] err_inj
`endif
);

  function automatic logic [7:0] gf256_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1D) : {x[6:0], 1'b0};
    end
    return p;
  endfunction

  // g(x) = prod (x + alpha^-j), j=1..16; 0x8E is alpha^-1. Coefficient i sits at bits [8*i +: 8].
  function automatic logic [127:0] gen_poly();
    logic [135:0] p;
    logic [7:0]   root;
    p    = 136'd1;
    root = 8'h01;
    for (int j = 1; j <= 16; j++) begin
      root = gf256_mul(root, 8'h8E);
      for (int k = 16; k >= 1; k--) begin
        p[8*k +: 8] = p[8*(k-1) +: 8] ^ gf256_mul(root, p[8*k +: 8]);
      end
      p[7:0] = gf256_mul(root, p[7:0]);
    end
    return p[127:0];
  endfunction

  localparam logic [127:0] GPOLY     = gen_poly();
  localparam logic [7:0]   BCNT_LAST = 8'(K - 1);
  localparam logic [3:0]   PCNT_LAST = 4'(NPAR - 1);

  typedef enum logic {
    ST_DATA,
    ST_PARITY
  } state_e;

  state_e           st_q, st_d;
  logic [7:0]       bcnt_q, bcnt_d;
  logic [3:0]       pcnt_q, pcnt_d;
  logic [15:0][7:0] par_q, par_d;
  logic [7:0]       out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             out_sop_q, out_sop_d;
  logic             out_last_q, out_last_d;

  logic       ld;
  logic [7:0] fb;
  logic [7:0] par_out;

`ifdef RS_ENC_ERR_INJECT_EN
  logic [7:0] err_q, err_d;
  assign par_out = par_q[15] ^ ((pcnt_q == 4'd0) ? err_q : 8'h00);
`else
  assign par_out = par_q[15];
`endif

  // Single output register: a new byte may load when it is empty or being drained.
  assign ld       = !out_valid_q || out_ready;
  assign in_ready = (st_q == ST_DATA) && ld;
  assign fb       = in_data ^ par_q[15];

  always_comb begin
    st_d        = st_q;
    bcnt_d      = bcnt_q;
    pcnt_d      = pcnt_q;
    par_d       = par_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_sop_d   = out_sop_q;
    out_last_d  = out_last_q;
`ifdef RS_ENC_ERR_INJECT_EN
    err_d       = err_q;
`endif
    if (ld) begin
      out_valid_d = 1'b0;
      if (st_q == ST_DATA) begin
        if (in_valid) begin
          out_data_d  = in_data;
          out_valid_d = 1'b1;
          out_sop_d   = (bcnt_q == 8'd0);
          out_last_d  = 1'b0;
          for (int i = 15; i >= 1; i--) begin
            par_d[i] = par_q[i-1] ^ gf256_mul(fb, GPOLY[8*i +: 8]);
          end
          par_d[0] = gf256_mul(fb, GPOLY[7:0]);
          if (bcnt_q == BCNT_LAST) begin
            st_d   = ST_PARITY;
            pcnt_d = 4'd0;
            bcnt_d = 8'd0;
`ifdef RS_ENC_ERR_INJECT_EN
            err_d  = err_inj;
`endif
          end else begin
            bcnt_d = bcnt_q + 8'd1;
          end
        end
      end else begin
        out_data_d  = par_out;
        out_valid_d = 1'b1;
        out_sop_d   = 1'b0;
        out_last_d  = (pcnt_q == PCNT_LAST);
        // Shifting zeros in leaves the register clear for the next codeword.
        par_d       = {par_q[14:0], 8'h00};
        pcnt_d      = pcnt_q + 4'd1;
        if (pcnt_q == PCNT_LAST) st_d = ST_DATA;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st_q        <= ST_DATA;
      bcnt_q      <= 8'd0;
      pcnt_q      <= 4'd0;
      par_q       <= '0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_last_q  <= 1'b0;
`ifdef RS_ENC_ERR_INJECT_EN
      err_q       <= 8'h00;
`endif
    end else begin
      st_q        <= st_d;
      bcnt_q      <= bcnt_d;
      pcnt_q      <= pcnt_d;
      par_q       <= par_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_last_q  <= out_last_d;
`ifdef RS_ENC_ERR_INJECT_EN
      err_q       <= err_d;
`endif
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_rs_encoder_stream.sv
// Bench for rs_encoder_stream: four instances (K = 1, 16, 100, 239) checked against a
// log/antilog GF(256) model that encodes by polynomial long division and verifies syndromes.
module tb_rs_encoder_stream;
  localparam int NL = 4;
  localparam logic [NL-1:0][7:0] KP = {8'd239, 8'd100, 8'd16, 8'd1};
`ifdef RS_ENC_ERR_INJECT_EN
  localparam logic [7:0] ERR = 8'h5A;
`else
  localparam logic [7:0] ERR = 8'h00;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst_n;
  logic [NL-1:0][7:0]  in_data;
  logic [NL-1:0][7:0]  out_data;
  logic [NL-1:0]       in_valid, in_ready, out_valid, out_ready, out_sop, out_last;

  for (genvar l = 0; l < NL; l++) begin : g_lane
    rs_encoder_stream #(.K(int'(KP[l])), .NPAR(16)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_data  (in_data[l]),
      .in_valid (in_valid[l]),
      .in_ready (in_ready[l]),
      .out_data (out_data[l]),
      .out_valid(out_valid[l]),
      .out_ready(out_ready[l]),
      .out_sop  (out_sop[l]),
      .out_last (out_last[l])
`ifdef RS_ENC_ERR_INJECT_EN
      ,
      .err_inj  (ERR)
`endif
    );
  end

  int         ex [0:509];
  int         lg [0:255];
  logic [7:0] gm [0:16];

  logic [9:0] expq [NL][$];   // {sop, last, data}
  logic [7:0] msgq [NL][$];
  logic [7:0] cwb  [NL][$];
  int         gen_idx [NL];
  int         cw_cnt  [NL];
  int         acc_cnt [NL];
  bit         stall_prev [NL];
  int         l3_out;
  bit         bub_chk;

  int n_vec = 0;
  int n_err = 0;

  function automatic int kof(input int l);
    return int'(KP[l]);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    if (a == 8'h00 || b == 8'h00) return 8'h00;
    return 8'(ex[lg[a] + lg[b]]);
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic build_model();
    logic [7:0] a;
    ex[0] = 1;
    for (int i = 1; i < 510; i++) begin
      int v;
      v = ex[i-1] << 1;
      if ((v & 256) != 0) v = v ^ 'h11D;
      ex[i] = v;
    end
    for (int i = 0; i < 255; i++) lg[ex[i]] = i;
    lg[0] = 0;
    for (int k = 0; k <= 16; k++) gm[k] = 8'h00;
    gm[0] = 8'h01;
    for (int j = 1; j <= 16; j++) begin
      a = 8'(ex[255 - j]);
      for (int k = 16; k >= 1; k--) gm[k] = gm[k-1] ^ gmul(a, gm[k]);
      gm[0] = gmul(a, gm[0]);
    end
  endtask

  task automatic gen_cw(input int l);
    int         k;
    logic [7:0] m [0:254];
    logic [7:0] r [0:254];
    logic [7:0] c;
    k = kof(l);
    for (int i = 0; i < k; i++) begin
      if (l == 3 && gen_idx[l] == 0)      m[i] = 8'h00;
      else if (l == 3 && gen_idx[l] == 1) m[i] = (i == k - 1) ? 8'h01 : 8'h00;
      else                                m[i] = 8'($urandom_range(0, 255));
      r[i] = m[i];
      msgq[l].push_back(m[i]);
    end
    for (int i = k; i < k + 16; i++) r[i] = 8'h00;
    // m(x)*x^16 mod g(x), highest degree first
    for (int i = 0; i < k; i++) begin
      c = r[i];
      for (int t = 1; t <= 16; t++) r[i+t] = r[i+t] ^ gmul(c, gm[16-t]);
    end
    r[k] = r[k] ^ ERR;
    for (int i = 0; i < k + 16; i++)
      expq[l].push_back({(i == 0), (i == k + 15), (i < k) ? m[i] : r[i]});
    gen_idx[l]++;
  endtask

  task automatic synd_check(input int l);
    logic [7:0] s;
    int         n;
    n = cwb[l].size();
    check($sformatf("lane%0d cw_len", l), n, kof(l) + 16);
    for (int j = 1; j <= 16; j++) begin
      s = 8'h00;
      for (int k = 0; k < n; k++) s = s ^ gmul(cwb[l][k], 8'(ex[(k * j) % 255]));
      check($sformatf("lane%0d syndrome S%0d", l, j), s, gmul(ERR, 8'(ex[(kof(l) * j) % 255])));
    end
    cwb[l].delete();
  endtask

  task automatic step(input bit full);
    logic [9:0] e;
    int         pos;
    for (int l = 0; l < NL; l++) begin
      if (msgq[l].size() == 0) gen_cw(l);
      in_valid[l]  = full ? 1'b1 : ($urandom_range(0, 3) != 0);
      in_data[l]   = in_valid[l] ? msgq[l][0] : 8'($urandom_range(0, 255));
      out_ready[l] = full ? 1'b1 : 1'($urandom_range(0, 1));
    end
    #1;
    for (int l = 0; l < NL; l++) begin
      if (stall_prev[l]) check($sformatf("lane%0d hold_valid", l), out_valid[l], 1);
      if (bub_chk && l == 3 && l3_out > 0 && l3_out < 510)
        check("lane3 no_bubble", out_valid[3], 1);
      if (out_valid[l]) begin
        check($sformatf("lane%0d exp_avail", l), (expq[l].size() != 0), 1);
        if (expq[l].size() != 0) begin
          e = expq[l][0];
          check($sformatf("lane%0d data", l), out_data[l], e[7:0]);
          check($sformatf("lane%0d sop", l),  out_sop[l],  e[9]);
          check($sformatf("lane%0d last", l), out_last[l], e[8]);
          if (out_ready[l]) begin
            void'(expq[l].pop_front());
            pos = cwb[l].size();
            if (l == 3 && cw_cnt[3] == 1 && pos >= 239)
              check("lane3 t2_parity_vs_g", out_data[3], gm[254 - pos] ^ ((pos == 239) ? ERR : 8'h00));
            if (l == 3) l3_out++;
            cwb[l].push_back(out_data[l]);
            if (out_last[l]) begin
              synd_check(l);
              cw_cnt[l]++;
            end
          end
        end
      end
      stall_prev[l] = out_valid[l] && !out_ready[l];
      if (in_valid[l] && in_ready[l]) begin
        void'(msgq[l].pop_front());
        acc_cnt[l] = (acc_cnt[l] + 1 == kof(l)) ? 0 : acc_cnt[l] + 1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    for (int l = 0; l < NL; l++) begin
      in_valid[l]  = 1'b0;
      in_data[l]   = 8'h00;
      out_ready[l] = 1'b1;
    end
    #1;
    for (int l = 0; l < NL; l++) begin
      check($sformatf("lane%0d rst out_valid", l), out_valid[l], 0);
      check($sformatf("lane%0d rst out_data", l),  out_data[l],  0);
      check($sformatf("lane%0d rst out_sop", l),   out_sop[l],   0);
      check($sformatf("lane%0d rst out_last", l),  out_last[l],  0);
      check($sformatf("lane%0d rst in_ready", l),  in_ready[l],  1);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int l = 0; l < NL; l++) begin
      expq[l].delete();
      msgq[l].delete();
      cwb[l].delete();
      gen_idx[l]    = 0;
      cw_cnt[l]     = 0;
      acc_cnt[l]    = 0;
      stall_prev[l] = 1'b0;
    end
    l3_out = 0;
  endtask

  initial begin
    int  cyc;
    logic [7:0] ev;
    rst_n     = 1'b1;
    in_valid  = '0;
    in_data   = '0;
    out_ready = '0;
    bub_chk   = 1'b0;
    build_model();

    check("pin alpha^8", ex[8], 'h1D);
    check("pin 0x8E*0x02", gmul(8'h8E, 8'h02), 'h01);
    check("pin 0x80*0x80", gmul(8'h80, 8'h80), 'h13);
    check("pin g monic", gm[16], 'h01);
    check("pin g0 = alpha^119", gm[0], ex[119]);
    ev = 8'h00;
    for (int k = 16; k >= 0; k--) ev = gmul(ev, 8'(ex[254])) ^ gm[k];
    check("pin g(alpha^-1)", ev, 'h00);

    #3;
    do_reset();

    // full-rate: lane 3 sends all-zero codeword, then 238x00 + 01, back to back
    bub_chk = 1'b1;
    for (int i = 0; i < 512; i++) step(1'b1);
    bub_chk = 1'b0;
    check("lane3 phaseA bytes", l3_out >= 510, 1);

    cyc = 0;
    while (cw_cnt[3] < 22 && cyc < 60000) begin
      step(1'b0);
      cyc++;
    end
    check("lane3 random codewords done", cw_cnt[3] >= 22, 1);

    cyc = 0;
    while (acc_cnt[3] != 101 && cyc < 5000) begin
      step(1'b0);
      cyc++;
    end
    check("lane3 reached byte 100", acc_cnt[3], 101);
    do_reset();

    bub_chk = 1'b1;
    for (int i = 0; i < 512; i++) step(1'b1);
    bub_chk = 1'b0;
    check("lane3 post-reset bytes", l3_out >= 510, 1);
    cyc = 0;
    while (cw_cnt[3] < 4 && cyc < 10000) begin
      step(1'b0);
      cyc++;
    end
    check("lane3 post-reset codewords", cw_cnt[3] >= 4, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
